conv_tile_sched: RTL
====================

CONV_TILE_SCHED -- requirements
Module: conv_tile_sched

Interface
REQ-001 Parameters SHALL be: SYSTOLIC_SIZE, default 16, PE rows/cols; BUFFER_SIZE, default 27, K = 3*3*3 reduction length; IFM_W, default 34, padded input width/height; OFM_W, default 32, output width/height; NUM_FILTER, default 16, output channels.
REQ-002 Ports SHALL be: clk  in  1  rising-edge clock; rst  in  1  reset, synchronous, active-high.
REQ-003 start  in  1  one-cycle request to run one full 3x34x34 -> 16x32x32 convolution.
REQ-004 wgt_re  out  1 and wgt_addr  out  9  are the weight RAM read and byte address (filter*27 + k).
REQ-005 ifm_re  out  1 and ifm_addr  out  12  are the IFM RAM read and byte address.
REQ-006 buf_we  out  1, buf_sel  out  4 and buf_idx  out  5  are the buffer write strobe, buffer number and element index, aligned to RAM read data.
REQ-007 wgt_phase  out  1  is high when buf_* targets weight buffers, low when it targets IFM buffers.
REQ-008 pe_clear  out  1  clears the accumulators; pe_en  out  1  advances the systolic array.
REQ-009 ofm_we  out  1 and ofm_addr  out  14  are the 128-bit OFM write strobe and element address of lane 0.
REQ-010 busy  out  1 and done  out  1  are run status.

Function
REQ-011 FSM states SHALL be IDLE, LOAD_WGT, LOAD_IFM, COMPUTE, WRITE, NEXT, DONE.
REQ-012 IDLE or DONE with start=1 SHALL enter LOAD_WGT next cycle, clear all counters and deassert done.
REQ-013 start while busy=1 SHALL be ignored.
REQ-014 LOAD_WGT SHALL issue exactly 432 reads: wgt_addr = f*27 + k, f = 0..15 outer, k = 0..26 inner, one per cycle.
REQ-015 Weights SHALL be loaded once per run; LOAD_WGT SHALL then enter LOAD_IFM.
REQ-016 Tile t (0..63) SHALL cover output row oy = t>>1 and columns ox0 = (t&1)*16 .. ox0+15, all 16 filters.
REQ-017 LOAD_IFM SHALL issue 432 reads, buffer b = 0..15 outer, k = 0..26 inner.
REQ-018 With k = c*9 + ky*3 + kx, ifm_addr SHALL be c*1156 + (oy+ky)*34 + (ox0+b+kx).
REQ-019 RAM read latency is 1 cycle: buf_we, buf_sel, buf_idx and wgt_phase SHALL be the re/counter values delayed one cycle.
REQ-020 The FSM SHALL leave a load state only after its final delayed buf_we has issued.
REQ-021 COMPUTE SHALL assert pe_clear in its first cycle only.
REQ-022 COMPUTE SHALL assert pe_en for exactly BUFFER_SIZE + 2*SYSTOLIC_SIZE - 1 = 58 consecutive cycles, starting in that first cycle.
REQ-023 WRITE SHALL assert ofm_we for 16 cycles, filter f = 0..15, with ofm_addr = f*1024 + oy*32 + ox0.
REQ-024 NEXT SHALL last one cycle: if t = 63 go to DONE, else increment t and go to LOAD_IFM.
REQ-025 DONE SHALL hold done=1 until start; busy SHALL be 1 in every state except IDLE and DONE.
REQ-026 All address arithmetic SHALL be unsigned and sized so the maximum IFM address (3467) and OFM address (16368) cannot wrap.
REQ-027 All strobes SHALL be registered outputs; no combinational path from start to any output.

Reset
REQ-028 rst=1 at any clock edge, including mid-run, SHALL force IDLE.
REQ-029 Reset SHALL zero all counters and drive every output to 0, including addresses, done and busy.
REQ-030 Any pipelined buf_we pending at reset SHALL be discarded.
REQ-031 The first start after reset release SHALL be accepted.

Structure
REQ-032 The state encoding, tile/load/compute length constants (432, 58, 64) and the address-width constants SHALL live in a shared package, conv_pkg.
REQ-033 One sub-module, ifm_addr_gen, SHALL map (c, ky, kx, oy, ox0, b) to ifm_addr.
REQ-034 ifm_addr_gen SHALL be combinational and registered by the parent.

Verification
REQ-035 Reset, then start pulse at cycle 0 -> busy=1 at cycle 1; wgt_re high cycles 1..432 with wgt_addr 0..431; buf_we with wgt_phase=1 high cycles 2..433.
REQ-036 Tile 0 load -> first ifm_addr = 0, k=26/b=0 gives 2*1156+2*34+2 = 2382, final read (b=15, k=26) gives 2397.
REQ-037 Tile 63 load -> b=15, k=26 addr = 2312+33*34+33 = 3467; WRITE f=15 -> ofm_addr 15*1024+31*32+16 = 16368.
REQ-038 Per tile -> pe_clear count 1, pe_en count 58, ofm_we count 16; over a full run 64 of each tile event; done rises once, then start re-runs with identical traces.
REQ-039 rst asserted mid-COMPUTE of tile 10 -> next cycle all outputs 0 with state IDLE; a new start completes normally.
REQ-040 start re-pulsed during LOAD_IFM -> no effect on counters, addresses or total cycle count.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared states, run lengths and address widths for the conv tile scheduler
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_WGT,
      LOAD_IFM,
      COMPUTE,
      WRITE,
      NEXT,
      DONE
   } state_t;

   localparam int LOAD_LEN    = 432;
   localparam int COMPUTE_LEN = 58;
   localparam int NUM_TILES   = 64;

   localparam int WGT_AW = 9;
   localparam int IFM_AW = 12;
   localparam int OFM_AW = 14;
   localparam int SEL_W  = 4;
   localparam int IDX_W  = 5;

   typedef logic [WGT_AW-1:0] wgt_addr_t;
   typedef logic [IFM_AW-1:0] ifm_addr_t;
   typedef logic [OFM_AW-1:0] ofm_addr_t;

   typedef struct packed {
      logic [1:0] c;
      logic [1:0] ky;
      logic [1:0] kx;
   } k_coord_t;

   // k = c*9 + ky*3 + kx
   function automatic k_coord_t split_k(input logic [IDX_W-1:0] k);
      k_coord_t r;
      r.c  = 2'(k / 5'd9);
      r.ky = 2'((k % 5'd9) / 5'd3);
      r.kx = 2'(k % 5'd3);
      return r;
   endfunction

endpackage

// File: rtl/conv_tile_sched_if.sv
// rtl/conv_tile_sched_if.sv - start request plus RAM, buffer, array and OFM strobes of the scheduler
interface conv_tile_sched_if;
   import conv_pkg::*;

   logic             start;
   logic             wgt_re;
   wgt_addr_t        wgt_addr;
   logic             ifm_re;
   ifm_addr_t        ifm_addr;
   logic             buf_we;
   logic [SEL_W-1:0] buf_sel;
   logic [IDX_W-1:0] buf_idx;
   logic             wgt_phase;
   logic             pe_clear;
   logic             pe_en;
   logic             ofm_we;
   ofm_addr_t        ofm_addr;
   logic             busy;
   logic             done;

   modport master (
      input  start,
      output wgt_re, wgt_addr, ifm_re, ifm_addr, buf_we, buf_sel, buf_idx, wgt_phase,
             pe_clear, pe_en, ofm_we, ofm_addr, busy, done
   );

   modport slave (
      output start,
      input  wgt_re, wgt_addr, ifm_re, ifm_addr, buf_we, buf_sel, buf_idx, wgt_phase,
             pe_clear, pe_en, ofm_we, ofm_addr, busy, done
   );

endinterface

// File: rtl/ifm_addr_gen.sv
// rtl/ifm_addr_gen.sv - combinational IFM byte address for one (c, ky, kx, oy, ox0, b) tap
module ifm_addr_gen
   import conv_pkg::*;
#(
   parameter int IFM_W = 34
) (
   input  logic [1:0] c,
   input  logic [1:0] ky,
   input  logic [1:0] kx,
   input  logic [4:0] oy,
   input  logic [4:0] ox0,
   input  logic [3:0] b,
   output ifm_addr_t  ifm_addr
);

   // every term fits in IFM_AW bits, so truncating the products never loses the result
   assign ifm_addr = ifm_addr_t'(c) * ifm_addr_t'(IFM_W * IFM_W)
                   + (ifm_addr_t'(oy) + ifm_addr_t'(ky)) * ifm_addr_t'(IFM_W)
                   + ifm_addr_t'(ox0) + ifm_addr_t'(b) + ifm_addr_t'(kx);

endmodule

// File: rtl/conv_tile_sched.sv
// rtl/conv_tile_sched.sv - sequences weight load, 64 IFM tiles, systolic compute and OFM write-back
module conv_tile_sched
   import conv_pkg::*;
#(
   parameter int SYSTOLIC_SIZE = 16,
   parameter int BUFFER_SIZE   = 27,
   parameter int IFM_W         = 34,
   parameter int OFM_W         = 32,
   parameter int NUM_FILTER    = 16
) (
   input logic              clk,
   input logic              rst,
   conv_tile_sched_if.master bus
);

   localparam logic [8:0] LD_END = 9'(LOAD_LEN);
   localparam logic [4:0] K_LAST = 5'(BUFFER_SIZE - 1);
   localparam logic [5:0] C_LAST = 6'(COMPUTE_LEN - 1);
   localparam logic [5:0] F_LAST = 6'(NUM_FILTER - 1);
   localparam logic [5:0] T_LAST = 6'(NUM_TILES - 1);

   state_t     state_q, state_n;
   logic [8:0] ld_q, ld_n;
   logic [3:0] outer_q, outer_n;
   logic [4:0] inner_q, inner_n;
   logic [5:0] cyc_q, cyc_n;
   logic [5:0] tile_q, tile_n;

   logic       wgt_re_n, ifm_re_n, pe_clear_n, pe_en_n, ofm_we_n, busy_n, done_n;
   wgt_addr_t  wgt_addr_n;
   ifm_addr_t  ifm_addr_n, gen_addr;
   ofm_addr_t  ofm_addr_n;
   k_coord_t   kc;
   logic [4:0] oy_n, ox0_n;
   logic       rd_any;

   assign kc     = split_k(inner_n);
   assign oy_n   = tile_n[5:1];
   assign ox0_n  = tile_n[0] ? 5'(SYSTOLIC_SIZE) : 5'd0;
   assign rd_any = bus.wgt_re | bus.ifm_re;

   ifm_addr_gen #(.IFM_W(IFM_W)) u_ifm_addr_gen (
      .c        (kc.c),
      .ky       (kc.ky),
      .kx       (kc.kx),
      .oy       (oy_n),
      .ox0      (ox0_n),
      .b        (outer_n),
      .ifm_addr (gen_addr)
   );

   always_comb begin
      state_n = state_q;
      ld_n    = ld_q;
      outer_n = outer_q;
      inner_n = inner_q;
      cyc_n   = cyc_q;
      tile_n  = tile_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_n = LOAD_WGT;
               ld_n    = '0;
               outer_n = '0;
               inner_n = '0;
               cyc_n   = '0;
               tile_n  = '0;
            end
         end
         LOAD_WGT, LOAD_IFM: begin
            // ld == LD_END is the drain cycle that lets the last delayed buf_we land
            if (ld_q == LD_END) begin
               state_n = (state_q == LOAD_WGT) ? LOAD_IFM : COMPUTE;
               ld_n    = '0;
               outer_n = '0;
               inner_n = '0;
               cyc_n   = '0;
            end else begin
               ld_n = ld_q + 9'd1;
               if (inner_q == K_LAST) begin
                  inner_n = '0;
                  outer_n = outer_q + 4'd1;
               end else begin
                  inner_n = inner_q + 5'd1;
               end
            end
         end
         COMPUTE: begin
            if (cyc_q == C_LAST) begin
               state_n = WRITE;
               cyc_n   = '0;
            end else begin
               cyc_n = cyc_q + 6'd1;
            end
         end
         WRITE: begin
            if (cyc_q == F_LAST) begin
               state_n = NEXT;
               cyc_n   = '0;
            end else begin
               cyc_n = cyc_q + 6'd1;
            end
         end
         NEXT: begin
            if (tile_q == T_LAST) begin
               state_n = DONE;
            end else begin
               state_n = LOAD_IFM;
               tile_n  = tile_q + 6'd1;
               ld_n    = '0;
               outer_n = '0;
               inner_n = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // outputs are decoded from the next state and then registered
   always_comb begin
      wgt_re_n   = (state_n == LOAD_WGT) && (ld_n != LD_END);
      ifm_re_n   = (state_n == LOAD_IFM) && (ld_n != LD_END);
      wgt_addr_n = '0;
      ifm_addr_n = '0;
      ofm_addr_n = '0;
      if (wgt_re_n) begin
         wgt_addr_n = wgt_addr_t'(outer_n) * wgt_addr_t'(BUFFER_SIZE) + wgt_addr_t'(inner_n);
      end
      if (ifm_re_n) begin
         ifm_addr_n = gen_addr;
      end
      pe_en_n    = (state_n == COMPUTE);
      pe_clear_n = pe_en_n && (cyc_n == 6'd0);
      ofm_we_n   = (state_n == WRITE);
      if (ofm_we_n) begin
         ofm_addr_n = ofm_addr_t'(cyc_n) * ofm_addr_t'(OFM_W * OFM_W)
                    + ofm_addr_t'(oy_n) * ofm_addr_t'(OFM_W) + ofm_addr_t'(ox0_n);
      end
      busy_n = !((state_n == IDLE) || (state_n == DONE));
      done_n = (state_n == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ld_q          <= '0;
         outer_q       <= '0;
         inner_q       <= '0;
         cyc_q         <= '0;
         tile_q        <= '0;
         bus.wgt_re    <= 1'b0;
         bus.wgt_addr  <= '0;
         bus.ifm_re    <= 1'b0;
         bus.ifm_addr  <= '0;
         bus.buf_we    <= 1'b0;
         bus.buf_sel   <= '0;
         bus.buf_idx   <= '0;
         bus.wgt_phase <= 1'b0;
         bus.pe_clear  <= 1'b0;
         bus.pe_en     <= 1'b0;
         bus.ofm_we    <= 1'b0;
         bus.ofm_addr  <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         state_q       <= state_n;
         ld_q          <= ld_n;
         outer_q       <= outer_n;
         inner_q       <= inner_n;
         cyc_q         <= cyc_n;
         tile_q        <= tile_n;
         bus.wgt_re    <= wgt_re_n;
         bus.wgt_addr  <= wgt_addr_n;
         bus.ifm_re    <= ifm_re_n;
         bus.ifm_addr  <= ifm_addr_n;
         bus.buf_we    <= rd_any;
         bus.buf_sel   <= rd_any ? outer_q : '0;
         bus.buf_idx   <= rd_any ? inner_q : '0;
         bus.wgt_phase <= bus.wgt_re;
         bus.pe_clear  <= pe_clear_n;
         bus.pe_en     <= pe_en_n;
         bus.ofm_we    <= ofm_we_n;
         bus.ofm_addr  <= ofm_addr_n;
         bus.busy      <= busy_n;
         bus.done      <= done_n;
      end
   end

endmodule
